// File: rtl/regfile_sb_if.sv
// Register-file scoreboard bus: read ports, write port, reservation,
// clear request and ready status, grouped for master (driver) and slave (array).
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]   raddr;
    logic [NREAD*XLEN-1:0] rdata;
    logic [NREAD-1:0]      rbusy;
    logic                  wen;
    logic [AW-1:0]         waddr;
    logic [XLEN-1:0]       wdata;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;
    logic                  clr_req;
    logic                  ready;

    modport master (
        output raddr, wen, waddr, wdata, rsv_en, rsv_addr, clr_req,
        input  rdata, rbusy, ready
    );

    modport slave (
        input  raddr, wen, waddr, wdata, rsv_en, rsv_addr, clr_req,
        output rdata, rbusy, ready
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register busy (scoreboard) bits. Contents are
// zeroed by a one-entry-per-cycle sweep after reset or on clr_req; reads
// are combinational with optional same-cycle write forwarding.

// One read lane: masks invalid/zero addresses and the not-ready state,
// and forwards the in-flight write when enabled.
module regfile_sb_rport #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            ready,
    input  logic            addr_ok,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] entry,
    input  logic            busy_bit,
    input  logic            wen,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            rbusy
);
    logic hit;

    // A write to the addressed register this cycle shadows the stored entry.
    assign hit = (BYPASS != 0) && wen && (waddr == addr);

    // Select forwarded, stored or zero data for this lane.
    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (ready && addr_ok) begin
            if (hit) begin
                rdata = wdata;
            end else begin
                rdata = entry;
                rbusy = busy_bit;
            end
        end
    end
endmodule

module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input  logic         clock,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    // Bit i set when address i is a real, writable register (not x0, < NREGS).
    function automatic logic [2**AW-1:0] addr_ok_map();
        logic [2**AW-1:0] m;
        m = '0;
        for (int i = 1; i < NREGS; i++) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [2**AW-1:0] ADDR_OK = addr_ok_map();

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state;
    logic [AW-1:0]   clr_ptr;
    logic            ready_q;
    logic [NREGS-1:0] busy;
    logic [XLEN-1:0] mem [NREGS];

    logic wr_go;
    logic rsv_go;

    // clr_req pre-empts any same-cycle write or reservation.
    assign wr_go  = ready_q && !bus.clr_req && bus.wen    && ADDR_OK[bus.waddr];
    assign rsv_go = ready_q && !bus.clr_req && bus.rsv_en && ADDR_OK[bus.rsv_addr];

    // Sweep sequencer: CLEAR walks clr_ptr across the array, READY serves traffic.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (bus.clr_req) begin
                        clr_ptr <= '0;
                    end else if (clr_ptr == AW'(NREGS - 1)) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                READY: begin
                    if (bus.clr_req) begin
                        state   <= CLEAR;
                        ready_q <= 1'b0;
                        clr_ptr <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    ready_q <= 1'b0;
                    clr_ptr <= '0;
                end
            endcase
        end
    end

    // Scoreboard: a write retires the reservation, a same-cycle reserve re-arms it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else if (ready_q && bus.clr_req) begin
            busy <= '0;
        end else begin
            if (wr_go)  busy[bus.waddr]    <= 1'b0;
            if (rsv_go) busy[bus.rsv_addr] <= 1'b1;
        end
    end

    // Storage has no reset; the sweep zeroes every entry before ready rises.
    always_ff @(posedge clock) begin
        if (!ready_q) begin
            mem[clr_ptr] <= '0;
        end else if (wr_go) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    logic [NREAD-1:0][XLEN-1:0] rd_lane;
    logic [NREAD-1:0]           rb_lane;

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = bus.raddr[k*AW +: AW];

        regfile_sb_rport #(
            .XLEN   (XLEN),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rport (
            .ready    (ready_q),
            .addr_ok  (ADDR_OK[ra]),
            .addr     (ra),
            .entry    (mem[ra]),
            .busy_bit (busy[ra]),
            .wen      (bus.wen),
            .waddr    (bus.waddr),
            .wdata    (bus.wdata),
            .rdata    (rd_lane[k]),
            .rbusy    (rb_lane[k])
        );
    end

    assign bus.rdata = rd_lane;
    assign bus.rbusy = rb_lane;
    assign bus.ready = ready_q;
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: data word width in bits.
REQ-002 SHALL have parameter NREGS, default 32: number of architectural registers, 2..64; AW = clog2(NREGS).
REQ-003 SHALL have parameter NREAD, default 2: number of independent read ports, 1..4.
REQ-004 SHALL have parameter BYPASS, default 1: 1 forwards same-cycle write data to reads, 0 disables forwarding.
REQ-005 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port raddr, input, NREAD*AW: read addresses; port k uses bits [k*AW +: AW].
REQ-008 SHALL have port rdata, output, NREAD*XLEN: read data; port k uses bits [k*XLEN +: XLEN].
REQ-009 SHALL have port rbusy, output, NREAD: per read port, 1 = the addressed register has a pending reservation.
REQ-010 SHALL have port wen, input, 1: write enable.
REQ-011 SHALL have port waddr, input, AW: write address.
REQ-012 SHALL have port wdata, input, XLEN: write data.
REQ-013 SHALL have port rsv_en, input, 1: reserve-destination request.
REQ-014 SHALL have port rsv_addr, input, AW: register to mark busy.
REQ-015 SHALL have port clr_req, input, 1: request a full register-array clear sweep.
REQ-016 SHALL have port ready, output, 1: 1 = array valid and accepting writes and reservations.

Function
REQ-017 SHALL implement a two-state FSM, CLEAR and READY, plus an AW-bit clear pointer clr_ptr.
REQ-018 In CLEAR, each rising edge SHALL write 0 to entry clr_ptr and increment clr_ptr.
REQ-019 On the edge that writes entry NREGS-1, the FSM SHALL move to READY; ready is high from that edge onward.
REQ-020 In CLEAR, rdata SHALL be all-zero, rbusy SHALL be all-zero, and wen and rsv_en SHALL be ignored.
REQ-021 In READY, clr_req=1 SHALL move the FSM to CLEAR on the next edge, set clr_ptr=0 and clear all busy bits; clr_req has priority over a same-cycle write or reservation, which are dropped.
REQ-022 In CLEAR, clr_req=1 SHALL restart the sweep with clr_ptr=0.
REQ-023 Register 0 SHALL always read 0 and never read busy; writes and reservations to address 0 SHALL be ignored.
REQ-024 Addresses >= NREGS SHALL be ignored for writes and reservations, and SHALL read 0 with rbusy=0.
REQ-025 Reads SHALL be combinational: rdata[k] = entry[raddr[k]] and rbusy[k] = busy[raddr[k]].
REQ-026 In READY, a write with wen=1 and a valid nonzero waddr SHALL update the entry at the edge and clear busy[waddr].
REQ-027 In READY, rsv_en=1 with a valid nonzero rsv_addr SHALL set busy[rsv_addr] at the edge.
REQ-028 When wen and rsv_en target the same address in the same cycle, the data SHALL be written and busy SHALL end at 1 (reservation wins).
REQ-029 When BYPASS=1, ready=1, wen=1 and waddr equals a nonzero, valid raddr[k], rdata[k] SHALL equal wdata and rbusy[k] SHALL be 0 in that same cycle.
REQ-030 When BYPASS=0, reads SHALL return the pre-edge value.
REQ-031 All read ports SHALL be independent; any number may address the same register.

Reset
REQ-032 While reset=0, the FSM SHALL be in CLEAR with clr_ptr=0, all busy bits 0 and ready=0, asynchronously; rdata=0 and rbusy=0.
REQ-033 After reset release, the sweep SHALL begin on the first rising edge, and ready SHALL rise at the NREGS-th edge.
REQ-034 Asserting reset mid-sweep or in READY SHALL restart from REQ-032 immediately.
REQ-035 The register array itself need not be asynchronously reset; the sweep guarantees zero contents before ready.

Verification
REQ-036 Release reset, NREGS=32 -> ready=0 for edges 1..31 and 1 at edge 32; all 32 registers then read 0.
REQ-037 Write x5=0xDEADBEEF with raddr0=5, BYPASS=1 -> rdata0=0xDEADBEEF in the same cycle; with BYPASS=0, same value appears only after the edge.
REQ-038 Reserve x7, then read x7 -> rbusy=1; write x7=0x12 -> rbusy=0 and rdata=0x12; a same-cycle write and reserve of x7 -> rdata=0x12 and rbusy=1.
REQ-039 Write x0=0xFFFFFFFF and reserve x0 -> x0 reads 0 with rbusy=0.
REQ-040 Pulse clr_req with x3=0x55 busy -> ready=0 next cycle and a same-cycle write is dropped; after 32 edges ready=1, x3=0, rbusy=0.
REQ-041 Drop reset at sweep edge 10 -> ready=0 immediately; after release, a full 32-edge sweep occurs again.
